// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV-M multiply/divide unit: Funct3 op codes,
// FSM state encoding and small op-decode helpers.
package mul_div_unit_pkg;

    // RV-M Funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Divide and remainder ops all have Funct3[2] set
    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One bit-step of the iterative multiplier/divider, purely combinational.
// Multiply: acc = {partial_hi, multiplier_lo}; add multiplicand when the
//   multiplier LSB is set, then shift the whole thing right by one.
// Divide (restoring): acc = {remainder, dividend/quotient}; shift left by one,
//   trial-subtract the divisor from the upper half, keep it if non-negative
//   and shift a 1 into the quotient, otherwise restore and shift in 0.
module mdu_iter_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [XLEN-1:0]     opnd,
    input  logic [2*XLEN-1:0]   acc_in,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] sub_diff;

    // Select multiply shift-add or divide shift-subtract for this bit
    always_comb begin
        add_sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        // Remainder is always below the divisor, so the shifted remainder fits
        // in XLEN+1 bits and the borrow lands in bit XLEN.
        sub_diff = acc_in[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (!is_div) begin
            acc_out = {add_sum, acc_in[XLEN-1:1]};
        end else if (!sub_diff[XLEN]) begin
            acc_out = {sub_diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {acc_in[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV-M multiply/divide unit. One bit per cycle in CALC, signs are
// stripped in PREP and re-applied in FIX. Divide-by-zero and signed overflow
// bypass CALC. Handshake: Start is taken only while Busy is low (IDLE or
// DONE); Done is a single-cycle pulse with Result/TagOut valid, and those
// outputs hold until the next op's FIX. Flush aborts and beats Start.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [XLEN-1:0]  SrcA,
    input  logic [XLEN-1:0]  SrcB,
    input  logic [TAG_W-1:0] TagIn,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [XLEN-1:0]  Result,
    output logic [TAG_W-1:0] TagOut,
    output logic [2:0]       DbgState
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   src_a_q;
    logic [XLEN-1:0]   src_b_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              special_q;
    logic [XLEN-1:0]   special_val_q;

    logic              accept;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_val;
    logic [2*XLEN-1:0] step_out;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;

    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && Start && !Flush;
    assign Busy     = (state == ST_PREP) || (state == ST_CALC) || (state == ST_FIX);
    assign Done     = (state == ST_DONE);
    assign DbgState = state;

    // Operand decode for PREP: magnitudes, signs and the CALC-bypass cases
    always_comb begin
        a_neg       = op_a_signed(op_q) & src_a_q[XLEN-1];
        b_neg       = op_b_signed(op_q) & src_b_q[XLEN-1];
        a_mag       = a_neg ? -src_a_q : src_a_q;
        b_mag       = b_neg ? -src_b_q : src_b_q;
        div_zero    = op_is_div(op_q) && (src_b_q == '0);
        div_ovf     = ((op_q == F3_DIV) || (op_q == F3_REM)) &&
                      (src_a_q == MOST_NEG) && (src_b_q == '1);
        special_val = '0;
        if (div_zero) begin
            // Funct3[1] distinguishes REM/REMU from DIV/DIVU
            special_val = op_q[1] ? src_a_q : '1;
        end else if (div_ovf) begin
            special_val = op_q[1] ? '0 : src_a_q;
        end
    end

    mdu_iter_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div (op_is_div(op_q)),
        .opnd   (opnd_q),
        .acc_in (acc_q),
        .acc_out(step_out)
    );

    // FIX: re-apply signs and pick the requested half / quotient / remainder
    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            F3_MUL:                       fix_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_val = quot;
            default:                      fix_val = rem;
        endcase
        if (special_q) begin
            fix_val = special_val_q;
        end
    end

    // Next-state logic; Flush overrides every transition including Start
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: state_next = Start ? ST_PREP : ST_IDLE;
            ST_PREP:          state_next = (div_zero || div_ovf) ? ST_FIX : ST_CALC;
            ST_CALC:          state_next = (cnt_q == CNT_ONE) ? ST_FIX : ST_CALC;
            ST_FIX:           state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
        if (Flush) begin
            state_next = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: capture, prepare, iterate and write back
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q          <= '0;
            src_a_q       <= '0;
            src_b_q       <= '0;
            tag_q         <= '0;
            opnd_q        <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            Result        <= '0;
            TagOut        <= '0;
        end else if (Flush) begin
            cnt_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= Funct3;
                src_a_q <= SrcA;
                src_b_q <= SrcB;
                tag_q   <= TagIn;
            end
            case (state)
                ST_PREP: begin
                    // Multiply iterates over the multiplier in the low half;
                    // divide shifts the dividend up through the low half.
                    if (op_is_div(op_q)) begin
                        acc_q  <= {{XLEN{1'b0}}, a_mag};
                        opnd_q <= b_mag;
                    end else begin
                        acc_q  <= {{XLEN{1'b0}}, b_mag};
                        opnd_q <= a_mag;
                    end
                    cnt_q         <= CNT_LOAD;
                    neg_res_q     <= a_neg ^ b_neg;
                    neg_rem_q     <= a_neg;
                    special_q     <= div_zero || div_ovf;
                    special_val_q <= special_val;
                end
                ST_CALC: begin
                    acc_q <= step_out;
                    cnt_q <= cnt_q - CNT_ONE;
                end
                ST_FIX: begin
                    Result <= fix_val;
                    TagOut <= tag_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
